latch_pipeline_stage: RTL and testbench
=======================================

# latch_pipeline_stage

Parametrised pipeline-stage latch that replaces per-stage hand-written latches between any two adjacent CPU pipeline stages. It registers a WIDTH-bit payload with a valid bit and obeys the shared stall vector: it passes, holds or inserts a bubble. It adds a synchronous flush and a sticky stall-protocol error flag. Saturating bubble and hold counters expose per-stage stall statistics for performance debug.

## Interface
- WIDTH, 32: payload width in bits; legal range 1..256.
- STAGE, 2: index of the producer stage in the stall vector; the consumer stage is STAGE+1.
- STALL_WIDTH, 6: width of the stall vector; STAGE+1 < STALL_WIDTH is required (elaboration error otherwise).
- BUBBLE_VALUE, 0: WIDTH-bit value driven on out_data for a bubble, a flush or invalid input.
- COUNTER_WIDTH, 16: width of each statistics counter.

- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- stall  in  STALL_WIDTH  pipeline stall vector; 1 = stage stalled.
- flush  in  1  synchronous kill of the latched instruction.
- counter_clear  in  1  synchronous clear of both counters and protocol_error.
- in_valid  in  1  producer payload valid.
- in_data  in  WIDTH  producer payload.
- out_valid  out  1  registered consumer valid.
- out_data  out  WIDTH  registered consumer payload.
- bubble_count  out  COUNTER_WIDTH  number of bubble-insert cycles, saturating.
- hold_count  out  COUNTER_WIDTH  number of cycles spent holding a valid payload, saturating.
- protocol_error  out  1  sticky; set when the stall vector is non-monotone at this boundary.

## Operation
- Let sp = stall[STAGE] and sc = stall[STAGE+1]. Each rising edge selects one action, highest priority first:
  1. flush = 1 → out_valid ← 0, out_data ← BUBBLE_VALUE.
  2. sp = 1, sc = 0 → bubble: out_valid ← 0, out_data ← BUBBLE_VALUE.
  3. sp = 0 → pass: out_valid ← in_valid; out_data ← in_data when in_valid = 1, otherwise BUBBLE_VALUE.
  4. sp = 1, sc = 1 → hold: out_valid and out_data keep their current values.
- Protocol rule: a legal stall vector is monotone, so sc = 1 implies sp = 1.
  - sp = 0 with sc = 1 is still handled as a pass (rule 3).
  - That same cycle sets protocol_error ← 1. It stays set until reset or counter_clear.
- Counters:
  - bubble_count increments on every edge where rule 2 is taken.
  - hold_count increments on every edge where rule 4 is taken and out_valid = 1 before the edge.
  - A flush cycle increments neither counter.
  - Both counters saturate at all-ones; they do not wrap.
  - counter_clear = 1 forces both counters and protocol_error to 0 on that edge. Clear wins over a simultaneous increment or error set.
  - counter_clear has no effect on out_valid or out_data.
- Flush and the stall rules act on the payload path only. The counters and the error flag are governed by the rules above regardless of flush, except that rules 2 and 4 are not taken in a flush cycle.

## Timing
- Reset values (asynchronous, visible without a clock edge):
  - out_valid = 0, out_data = BUBBLE_VALUE.
  - bubble_count = 0, hold_count = 0, protocol_error = 0.
- Reset asserted mid-hold or mid-bubble discards the payload immediately. The first edge after reset deasserts acts normally on the inputs present at that edge.
- Latency: in_data and in_valid appear on out_data and out_valid one cycle after the capturing edge. There is no combinational path from any input to any output.
- Hold duration is unbounded; the payload is stable for every edge with sp = sc = 1.
- After a bubble with sp still 1 and sc now 1, the stage holds the bubble: out_valid stays 0 and hold_count does not increment.
- Counters and protocol_error update on the same edge as the payload action that caused them.

## Test plan
- **Reset:** set stall = 6'b000000, in_valid = 1, in_data = 32'h1234_5678, clock once, then assert reset between edges. out_valid drops to 0 and out_data to 0 immediately, without waiting for an edge.
- **Pass, hold, release:** STAGE = 2, in_data = 32'hDEAD_BEEF, in_valid = 1 with stall = 0 for one edge, then stall = 6'b001111 for 3 edges with in_data = 32'h0. out_data stays 32'hDEAD_BEEF with out_valid = 1 and hold_count = 3. With stall = 0, the next edge passes the new input.
- **Bubble:** apply stall = 6'b000111 for one edge. out_valid = 0, out_data = BUBBLE_VALUE, bubble_count = 1. Then apply stall = 6'b001111 for 2 edges: the bubble is held and hold_count is unchanged.
- **Flush priority:** with a valid payload held and stall = 6'b001111, assert flush for one edge. out_valid = 0, out_data = 0, and neither counter changes.
- **Protocol error:** apply stall = 6'b001000 with in_valid = 1 and in_data = 32'hA5A5_A5A5. The payload passes and protocol_error = 1, and it stays 1 after stall = 0. A counter_clear edge returns it to 0.
- **Saturation:** COUNTER_WIDTH = 4 with 20 consecutive bubble edges gives bubble_count = 4'hF. counter_clear asserted together with a bubble edge gives bubble_count = 0.

Source files
------------

// File: rtl/latch_pipeline_stage.sv
// Pipeline-stage latch between stage STAGE and STAGE+1: pass, hold, bubble or flush a payload.
// Latency: one cycle from the capturing edge to out_valid/out_data; every output is registered.
// Backpressure: the shared stall vector. A stalled consumer holds the payload; a stalled producer alone inserts a bubble.
module latch_pipeline_stage #(
  parameter int unsigned           WIDTH         = 32,
  parameter int unsigned           STAGE         = 2,
  parameter int unsigned           STALL_WIDTH   = 6,
  parameter logic [WIDTH-1:0]      BUBBLE_VALUE  = '0,
  parameter int unsigned           COUNTER_WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [STALL_WIDTH-1:0]   stall,
  input  logic                     flush,
  input  logic                     counter_clear,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic [COUNTER_WIDTH-1:0] bubble_count,
  output logic [COUNTER_WIDTH-1:0] hold_count,
  output logic                     protocol_error
);

  // Elaboration checks on the parameter ranges this stage can support.
  if (WIDTH < 1 || WIDTH > 256) begin : g_bad_width
    $error("latch_pipeline_stage: WIDTH must be in 1..256");
  end
  if (STAGE + 1 >= STALL_WIDTH) begin : g_bad_stage
    $error("latch_pipeline_stage: STAGE+1 must be below STALL_WIDTH");
  end

  typedef enum logic [1:0] {
    ACT_FLUSH  = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_PASS   = 2'd2,
    ACT_HOLD   = 2'd3
  } action_e;

  localparam logic [COUNTER_WIDTH-1:0] COUNT_MAX = '1;

  logic    sp;
  logic    sc;
  logic    stall_bad;
  logic    hold_inc;
  action_e action;

  // Only two bits of the stall vector matter at this boundary; the rest are
  // folded into a deliberately unused net.
  logic    unused_stall;
  assign unused_stall = ^stall;

  assign sp        = stall[STAGE];
  assign sc        = stall[STAGE+1];
  // A stalled consumer with a running producer is a non-monotone stall vector.
  assign stall_bad = sc & ~sp;
  // Only holding a real instruction counts as a hold cycle; a held bubble does not.
  assign hold_inc  = (action == ACT_HOLD) & out_valid;

  // Select the payload action for this edge, highest priority first.
  always_comb begin
    action = ACT_HOLD;
    if (flush) begin
      action = ACT_FLUSH;
    end else if (sp && !sc) begin
      action = ACT_BUBBLE;
    end else if (!sp) begin
      action = ACT_PASS;
    end
  end

  // Payload register: holding is simply not writing.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= BUBBLE_VALUE;
    end else begin
      case (action)
        ACT_FLUSH, ACT_BUBBLE: begin
          out_valid <= 1'b0;
          out_data  <= BUBBLE_VALUE;
        end
        ACT_PASS: begin
          out_valid <= in_valid;
          out_data  <= in_valid ? in_data : BUBBLE_VALUE;
        end
        default: begin
          out_valid <= out_valid;
          out_data  <= out_data;
        end
      endcase
    end
  end

  // Saturating bubble counter; clear wins over an increment.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bubble_count <= '0;
    end else if (counter_clear) begin
      bubble_count <= '0;
    end else if (action == ACT_BUBBLE && bubble_count != COUNT_MAX) begin
      bubble_count <= bubble_count + 1'b1;
    end
  end

  // Saturating hold counter; clear wins over an increment.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_count <= '0;
    end else if (counter_clear) begin
      hold_count <= '0;
    end else if (hold_inc && hold_count != COUNT_MAX) begin
      hold_count <= hold_count + 1'b1;
    end
  end

  // Sticky protocol error flag, independent of flush; clear wins over a set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      protocol_error <= 1'b0;
    end else if (counter_clear) begin
      protocol_error <= 1'b0;
    end else if (stall_bad) begin
      protocol_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_latch_pipeline_stage.sv
// Bench for latch_pipeline_stage: directed scenarios plus random cycles against a scoreboard.
// Two instances share stimulus; the second uses 4-bit counters to reach saturation quickly.
// Expected values come from a behavioural model evaluated as each cycle's stimulus is driven.
module tb_latch_pipeline_stage;

  logic        clock;
  logic        reset;
  logic [5:0]  stall;
  logic        flush;
  logic        counter_clear;
  logic        in_valid;
  logic [31:0] in_data;

  logic        out_valid,  out_valid4;
  logic [31:0] out_data,   out_data4;
  logic [15:0] bubble_count, hold_count;
  logic [3:0]  bubble_count4, hold_count4;
  logic        protocol_error, protocol_error4;

  latch_pipeline_stage #(.WIDTH(32), .STAGE(2), .STALL_WIDTH(6),
                         .BUBBLE_VALUE(32'h0), .COUNTER_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .counter_clear(counter_clear), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .bubble_count(bubble_count),
    .hold_count(hold_count), .protocol_error(protocol_error));

  latch_pipeline_stage #(.WIDTH(32), .STAGE(2), .STALL_WIDTH(6),
                         .BUBBLE_VALUE(32'h0), .COUNTER_WIDTH(4)) dut4 (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .counter_clear(counter_clear), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid4), .out_data(out_data4), .bubble_count(bubble_count4),
    .hold_count(hold_count4), .protocol_error(protocol_error4));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        v;
    logic [31:0] d;
    int          b16;
    int          h16;
    int          b4;
    int          h4;
    logic        pe;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;

  // Reference model state
  logic        m_valid;
  logic [31:0] m_data;
  int          m_b16, m_h16, m_b4, m_h4;
  logic        m_pe;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v, input int max);
    return (v < max) ? v + 1 : v;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_data = 32'h0;
    m_b16 = 0; m_h16 = 0; m_b4 = 0; m_h4 = 0; m_pe = 1'b0;
  endtask

  task automatic model_edge(input logic [5:0] st, input logic fl, input logic cc,
                            input logic iv, input logic [31:0] id);
    logic sp, sc, do_bub, do_hold;
    sp      = st[2];
    sc      = st[3];
    do_bub  = !fl && sp && !sc;
    do_hold = !fl && sp && sc && m_valid;
    if (do_bub)  begin m_b16 = sat(m_b16, 65535); m_b4 = sat(m_b4, 15); end
    if (do_hold) begin m_h16 = sat(m_h16, 65535); m_h4 = sat(m_h4, 15); end
    if (!sp && sc) m_pe = 1'b1;
    if (cc) begin m_b16 = 0; m_h16 = 0; m_b4 = 0; m_h4 = 0; m_pe = 1'b0; end
    if (fl || do_bub) begin
      m_valid = 1'b0; m_data = 32'h0;
    end else if (!sp) begin
      m_valid = iv; m_data = iv ? id : 32'h0;
    end
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("out_valid",  {31'd0, out_valid},      {31'd0, e.v});
      check("out_data",   out_data,                e.d);
      check("bubble16",   {16'd0, bubble_count},   e.b16);
      check("hold16",     {16'd0, hold_count},     e.h16);
      check("perr",       {31'd0, protocol_error}, {31'd0, e.pe});
      check("bubble4",    {28'd0, bubble_count4},  e.b4);
      check("hold4",      {28'd0, hold_count4},    e.h4);
      check("out_data4",  out_data4,               e.d);
    end
  endtask

  task automatic step(input logic [5:0] st, input logic fl, input logic cc,
                      input logic iv, input logic [31:0] id);
    exp_t e;
    stall = st; flush = fl; counter_clear = cc; in_valid = iv; in_data = id;
    model_edge(st, fl, cc, iv, id);
    e.v = m_valid; e.d = m_data; e.b16 = m_b16; e.h16 = m_h16;
    e.b4 = m_b4; e.h4 = m_h4; e.pe = m_pe;
    sb.push_back(e);
    @(posedge clock);
    #1;
    compare_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; stall = '0; flush = 1'b0; counter_clear = 1'b0;
    in_valid = 1'b0; in_data = '0;
    model_reset();
    #1;
    check("rst_valid", {31'd0, out_valid},      32'd0);
    check("rst_data",  out_data,                32'd0);
    check("rst_bub",   {16'd0, bubble_count},   32'd0);
    check("rst_hold",  {16'd0, hold_count},     32'd0);
    check("rst_perr",  {31'd0, protocol_error}, 32'd0);
    #1 reset = 1'b0;

    // Asynchronous reset between edges
    step(6'b000000, 0, 0, 1, 32'h1234_5678);
    check("pre_rst_data", out_data, 32'h1234_5678);
    reset = 1'b1;
    #1;
    check("async_rst_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_data",  out_data,           32'd0);
    model_reset();
    #1 reset = 1'b0;

    // Pass, hold three edges, release
    step(6'b000000, 0, 0, 1, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) step(6'b001111, 0, 0, 1, 32'h0);
    check("hold_data",  out_data,              32'hDEAD_BEEF);
    check("hold_valid", {31'd0, out_valid},    32'd1);
    check("hold_cnt",   {16'd0, hold_count},   32'd3);
    step(6'b000000, 0, 0, 1, 32'h1111_2222);
    check("release_data", out_data, 32'h1111_2222);

    // Bubble, then hold the bubble
    step(6'b000111, 0, 0, 1, 32'h3333_4444);
    check("bubble_valid", {31'd0, out_valid},    32'd0);
    check("bubble_cnt",   {16'd0, bubble_count}, 32'd1);
    for (int i = 0; i < 2; i++) step(6'b001111, 0, 0, 1, 32'h5555_6666);
    check("held_bubble_valid", {31'd0, out_valid},  32'd0);
    check("held_bubble_hold",  {16'd0, hold_count}, 32'd3);

    // Flush beats hold
    step(6'b000000, 0, 0, 1, 32'hCAFE_F00D);
    step(6'b001111, 0, 0, 1, 32'h0);
    check("pre_flush_hold", {16'd0, hold_count}, 32'd4);
    step(6'b001111, 1, 0, 1, 32'h0);
    check("flush_valid", {31'd0, out_valid},    32'd0);
    check("flush_data",  out_data,              32'd0);
    check("flush_hold",  {16'd0, hold_count},   32'd4);
    check("flush_bub",   {16'd0, bubble_count}, 32'd1);

    // Protocol error: non-monotone stall still passes
    step(6'b001000, 0, 0, 1, 32'hA5A5_A5A5);
    check("perr_data", out_data,                32'hA5A5_A5A5);
    check("perr_set",  {31'd0, protocol_error}, 32'd1);
    step(6'b000000, 0, 0, 0, 32'h0);
    check("perr_sticky", {31'd0, protocol_error}, 32'd1);
    step(6'b000000, 0, 1, 0, 32'h0);
    check("perr_clear", {31'd0, protocol_error}, 32'd0);

    // Saturation of the narrow counters
    for (int i = 0; i < 20; i++) step(6'b000111, 0, 0, 1, 32'h0);
    check("sat4",  {28'd0, bubble_count4}, 32'd15);
    check("bub16", {16'd0, bubble_count},  32'd20);
    step(6'b000111, 0, 1, 1, 32'h0);
    check("clear_wins", {28'd0, bubble_count4}, 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(6'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 24) == 0),
           1'($urandom), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
